// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types and helpers for the async-FIFO read-side arbiter.
package rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } rd_arb_state_e;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Consumer handshake and FIFO read-port bundle; master = arbiter side.
interface fifo_rd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) ();

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rdy;
    logic [NUM_REQ-1:0] gnt;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_rdata;
    logic               fifo_r_en;

    modport master (
        input  req, rdy, fifo_empty, fifo_rdata,
        output gnt, out_valid, out_data, fifo_r_en
    );

    modport slave (
        output req, rdy, fifo_empty, fifo_rdata,
        input  gnt, out_valid, out_data, fifo_r_en
    );

endinterface

// File: rtl/fifo_rd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         pick_oh,
    output logic [$clog2(NUM_REQ)-1:0] pick_idx,
    output logic                       pick_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Scan candidates in rotation order starting one past the pointer.
    always_comb begin
        pick_oh  = {NUM_REQ{1'b0}};
        pick_idx = {IDX_W{1'b0}};
        pick_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDX_W-1:0] cand_s;
            cand_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!pick_any && req[cand_s]) begin
                pick_any        = 1'b1;
                pick_oh[cand_s] = 1'b1;
                pick_idx        = cand_s;
            end else begin
                pick_any = pick_any;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst scheduler for the async-FIFO read port (rclk domain).
// Optional RD_ARB_STATS_EN adds per-consumer saturating handshake counters on stat_cnt.
module fifo_rd_arbiter
    import rd_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       rclk,
    input  logic                       rrst_n,
`ifdef RD_ARB_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0]  stat_cnt,
`endif
    fifo_rd_arbiter_if.master          bus
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    rd_arb_state_e      state_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [IDX_W-1:0]   gidx_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [BEAT_W-1:0]  beat_r;
    logic               out_valid_r;
    logic [DATA_W-1:0]  out_data_r;

    logic [NUM_REQ-1:0] pick_oh_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               req_g_s;
    logic               rdy_g_s;
    logic               pop_s;
    logic               accept_s;
    logic               last_beat_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req      (bus.req),
        .ptr      (ptr_r),
        .pick_oh  (pick_oh_s),
        .pick_idx (pick_idx_s),
        .pick_any (pick_any_s)
    );

    assign req_g_s     = bus.req[gidx_r];
    assign rdy_g_s     = bus.rdy[gidx_r];
    assign last_beat_s = (beat_r == BEAT_W'(MAX_BURST - 1));
    // Only the granted consumer's rdy counts; IDLE never holds a word.
    assign accept_s    = out_valid_r & rdy_g_s & (state_r != IDLE);
    assign pop_s       = (state_r == BURST) & ~bus.fifo_empty & req_g_s &
                         (~out_valid_r | rdy_g_s) & (beat_r < BEAT_W'(MAX_BURST));

    assign bus.fifo_r_en = pop_s;
    assign bus.gnt       = gnt_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    // Grant FSM plus output register stage.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_r     <= IDLE;
            gnt_r       <= {NUM_REQ{1'b0}};
            gidx_r      <= {IDX_W{1'b0}};
            ptr_r       <= IDX_W'(NUM_REQ - 1);
            beat_r      <= {BEAT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            if (pop_s) begin
                out_data_r  <= bus.fifo_rdata;
                out_valid_r <= 1'b1;
                beat_r      <= beat_r + BEAT_W'(1);
            end else if (accept_s) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (pick_any_s && !bus.fifo_empty) begin
                        gnt_r   <= pick_oh_s;
                        gidx_r  <= pick_idx_s;
                        beat_r  <= {BEAT_W{1'b0}};
                        state_r <= BURST;
                    end
                end
                BURST: begin
                    if ((pop_s && last_beat_s) || !req_g_s || bus.fifo_empty) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Keep the grant until the held word reaches its owner.
                    if (!out_valid_r || accept_s) begin
                        gnt_r   <= {NUM_REQ{1'b0}};
                        ptr_r   <= gidx_r;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= {NUM_REQ{1'b0}};
                end
            endcase
        end
    end

`ifdef RD_ARB_STATS_EN
    logic [STAT_W-1:0] stat_r [NUM_REQ];

    // Per-consumer delivered-word counters, saturating.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_r[i] <= {STAT_W{1'b0}};
            end
        end else if (accept_s) begin
            stat_r[gidx_r] <= sat_inc(stat_r[gidx_r]);
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_cnt[gi*STAT_W +: STAT_W] = stat_r[gi];
    end
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a behavioural FIFO read port model.
module tb_fifo_rd_arbiter;

    logic rclk = 1'b0;
    logic rrst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 rclk = ~rclk;

    fifo_rd_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

`ifdef RD_ARB_STATS_EN
    logic [63:0] stat_cnt;
`endif

    fifo_rd_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
`ifdef RD_ARB_STATS_EN
        .stat_cnt (stat_cnt),
`endif
        .bus      (bus)
    );

    // FIFO model: initial block pushes, pop strobe advances rd_ptr.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_rdata = mem[rd_ptr];

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rd_ptr <= 8'd0;
        else if (bus.fifo_r_en && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 8'd1;
    end

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    int         cyc = 0;
    logic [7:0] rx_data [0:127];
    int         rx_who [0:127];
    int         rx_n = 0;
    int         pop_cyc [0:127];
    int         pop_n = 0;
    int         viol_empty = 0;
    int         viol_oh = 0;

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rrst_n) begin
            if (bus.out_valid && |(bus.gnt & bus.rdy)) begin
                rx_data[rx_n] <= bus.out_data;
                rx_who[rx_n]  <= oh2idx(bus.gnt);
                rx_n          <= rx_n + 1;
            end
            if (bus.fifo_r_en) begin
                pop_cyc[pop_n] <= cyc;
                pop_n          <= pop_n + 1;
            end
        end
    end

    always @(negedge rclk) begin
        if (bus.fifo_r_en && bus.fifo_empty) viol_empty <= viol_empty + 1;
        if ($countones(bus.gnt) > 1) viol_oh <= viol_oh + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rx(input string tag, input int idx, input int who, input logic [7:0] d);
        chk({tag, "_who"}, 64'(rx_who[idx]), 64'(who));
        chk({tag, "_data"}, 64'(rx_data[idx]), 64'(d));
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic do_reset();
        rrst_n  = 1'b0;
        wr_ptr  = 8'd0;
        bus.req = 4'b0000;
        bus.rdy = 4'b0000;
        repeat (3) tick();
        rrst_n = 1'b1;
        tick();
    endtask

    initial begin
        int base;
        int pb;
        rrst_n  = 1'b0;
        wr_ptr  = 8'd0;
        bus.req = 4'b0000;
        bus.rdy = 4'b0000;
        repeat (2) tick();
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_ren", 64'(bus.fifo_r_en), 64'd0);
        rrst_n = 1'b1;
        tick();

        // Single consumer: 4 back-to-back, 2 idle cycles, then 2 more.
        base = rx_n; pb = pop_n;
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
        bus.req = 4'b0001;
        bus.rdy = 4'b1111;
        tick();
        chk("t1_gnt", 64'(bus.gnt), 64'b0001);
        chk("t1_valid0", 64'(bus.out_valid), 64'd0);
        chk("t1_ren", 64'(bus.fifo_r_en), 64'd1);
        tick();
        chk("t1_valid1", 64'(bus.out_valid), 64'd1);
        chk("t1_data0", 64'(bus.out_data), 64'h10);
        repeat (14) tick();
        chk("t1_count", 64'(rx_n - base), 64'd6);
        chk("t1_pops", 64'(pop_n - pb), 64'd6);
        for (int i = 0; i < 6; i++) chk_rx("t1_rx", base + i, 0, 8'h10 + 8'(i));
        for (int i = 1; i < 6; i++)
            chk("t1_pop_gap", 64'(pop_cyc[pb + i] - pop_cyc[pb + i - 1]), (i == 4) ? 64'd3 : 64'd1);
        chk("t1_gnt_end", 64'(bus.gnt), 64'd0);

        // Round robin across all four consumers.
        do_reset();
        base = rx_n;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        bus.req = 4'b1111;
        bus.rdy = 4'b1111;
        repeat (40) tick();
        chk("t2_count", 64'(rx_n - base), 64'd16);
        for (int i = 0; i < 16; i++) chk_rx("t2_rx", base + i, i / 4, 8'h20 + 8'(i));
        chk("t2_gnt_end", 64'(bus.gnt), 64'd0);
`ifdef RD_ARB_STATS_EN
        chk("t2_stats", stat_cnt, {16'd4, 16'd4, 16'd4, 16'd4});
`endif

        // Backpressure mid-burst.
        do_reset();
        base = rx_n;
        for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
        bus.req = 4'b0001;
        bus.rdy = 4'b0001;
        tick();
        tick();
        chk("t3_data0", 64'(bus.out_data), 64'h40);
        bus.rdy = 4'b0000;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_hold_data", 64'(bus.out_data), 64'h40);
            chk("t3_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t3_hold_ren", 64'(bus.fifo_r_en), 64'd0);
            if (k < 2) tick();
        end
        bus.rdy = 4'b0001;
        #1;
        chk("t3_resume_ren", 64'(bus.fifo_r_en), 64'd1);
        repeat (16) tick();
        chk("t3_count", 64'(rx_n - base), 64'd6);
        for (int i = 0; i < 6; i++) chk_rx("t3_rx", base + i, 0, 8'h40 + 8'(i));

        // FIFO runs empty mid-burst.
        do_reset();
        base = rx_n;
        push(8'h50);
        push(8'h51);
        bus.req = 4'b0001;
        bus.rdy = 4'b0001;
        tick();
        chk("t4_gnt", 64'(bus.gnt), 64'b0001);
        tick();
        chk("t4_data0", 64'(bus.out_data), 64'h50);
        tick();
        chk("t4_data1", 64'(bus.out_data), 64'h51);
        chk("t4_ren_empty", 64'(bus.fifo_r_en), 64'd0);
        tick();
        chk("t4_drain_gnt", 64'(bus.gnt), 64'b0001);
        chk("t4_drain_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t4_idle_gnt", 64'(bus.gnt), 64'd0);
        repeat (3) tick();
        chk("t4_count", 64'(rx_n - base), 64'd2);
        chk_rx("t4_rx0", base, 0, 8'h50);
        chk_rx("t4_rx1", base + 1, 0, 8'h51);

        // Consumer 1 drops req after its first pop; grant rotates to 2.
        do_reset();
        base = rx_n;
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        bus.req = 4'b0010;
        bus.rdy = 4'b0010;
        tick();
        chk("t5_gnt1", 64'(bus.gnt), 64'b0010);
        tick();
        chk("t5_data0", 64'(bus.out_data), 64'h60);
        bus.req = 4'b0100;
        #1;
        chk("t5_drop_ren", 64'(bus.fifo_r_en), 64'd0);
        tick();
        chk("t5_drain_gnt", 64'(bus.gnt), 64'b0010);
        chk("t5_drain_valid", 64'(bus.out_valid), 64'd0);
        bus.rdy = 4'b0110;
        tick();
        chk("t5_idle_gnt", 64'(bus.gnt), 64'd0);
        tick();
        chk("t5_gnt2", 64'(bus.gnt), 64'b0100);
        repeat (12) tick();
        chk("t5_count", 64'(rx_n - base), 64'd4);
        chk_rx("t5_rx0", base, 1, 8'h60);
        for (int i = 1; i < 4; i++) chk_rx("t5_rx", base + i, 2, 8'h60 + 8'(i));

        // Asynchronous reset while a word is held.
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h70 + 8'(i));
        bus.req = 4'b0001;
        bus.rdy = 4'b0000;
        tick();
        tick();
        chk("t6_pre_valid", 64'(bus.out_valid), 64'd1);
        chk("t6_pre_data", 64'(bus.out_data), 64'h70);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("t6_gnt", 64'(bus.gnt), 64'd0);
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_data", 64'(bus.out_data), 64'd0);
        chk("t6_ren", 64'(bus.fifo_r_en), 64'd0);
`ifdef RD_ARB_STATS_EN
        chk("t6_stats", stat_cnt, 64'd0);
`endif
        wr_ptr = 8'd0;
        tick();
        rrst_n = 1'b1;
        tick();

        chk("no_pop_when_empty", 64'(viol_empty), 64'd0);
        chk("gnt_onehot", 64'(viol_oh), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
